dmem_axil_ctrl: RTL
===================

# dmem_axil_ctrl

AXI4-Lite slave controller that sequences the single-port-write/single-port-read data memory (`data_mem`) on behalf of the SoC interconnect. It accepts one read or write transaction at a time and drives the memory's write strobe, byte enables and word addresses. It also absorbs the memory's one-cycle synchronous read latency and returns AXI responses. It sits between the AXI4-Lite crossbar and `data_mem`; `data_mem` is instantiated beside it at SoC level, not inside it.

## Interface
- `ADDR_WIDTH`, 12: AXI byte-address width.
- `MEM_WORDS`, 256: memory depth in 32-bit words. Must be a power of two; byte addresses at or above `MEM_WORDS*4` are out of range.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_awaddr` in ADDR_WIDTH; `s_awvalid` in 1; `s_awready` out 1.
- `s_wdata` in 32; `s_wstrb` in 4; `s_wvalid` in 1; `s_wready` out 1.
- `s_bresp` out 2; `s_bvalid` out 1; `s_bready` in 1.
- `s_araddr` in ADDR_WIDTH; `s_arvalid` in 1; `s_arready` out 1.
- `s_rdata` out 32; `s_rresp` out 2; `s_rvalid` out 1; `s_rready` in 1.
- `mem_write`  out  1  memory write strobe. Single-cycle pulse.
- `byte_en`  out  4  byte enables to memory.
- `write_addr`, `read_addr`  out  12  word index (byte address `>>2`, zero-extended).
- `write_data`  out  32  memory write data.
- `read_data`  in  32  memory read data. Valid the cycle after `read_addr` is presented.

## Operation
- FSM states: IDLE, W_ACC, W_MEM, W_RESP, R_ACC, R_MEM, R_DATA, R_RESP.
- IDLE: a write request is pending when `s_awvalid && s_wvalid`. The controller never accepts AW without W. A read request is pending when `s_arvalid`.
  - Only one request pending: grant it.
  - Both pending: grant the type not granted last, tracked by a `last_was_write` flag. Reset value is 0, so the write wins the first tie.
- W_ACC: `s_awready = s_wready = 1` for exactly one cycle. Capture the address, data and strobe → W_MEM.
- W_MEM:
  - `mem_write = 1` only if the address is in range and `wstrb != 0`.
  - `byte_en = wstrb`; `write_addr` = captured word index.
  - → W_RESP.
- W_RESP: `s_bvalid = 1`; `s_bresp` = OKAY, or SLVERR if out of range. Hold until `s_bready`, then → IDLE.
- R_ACC: `s_arready = 1` for one cycle. Capture the address → R_MEM.
- R_MEM: `read_addr` = captured word index → R_DATA.
- R_DATA:
  - Latch `read_data` into the `s_rdata` register, or latch 0 if out of range.
  - Set `s_rresp` = OKAY or SLVERR.
  - → R_RESP.
- R_RESP: `s_rvalid = 1`. Hold `s_rdata` and `s_rresp` stable until `s_rready`, then → IDLE.
- Word index = `addr[ADDR_WIDTH-1:2]`, truncated to `log2(MEM_WORDS)` bits and zero-extended to 12. The low two address bits are ignored; no misalignment error is raised.
- Out-of-range writes never assert `mem_write`.
- `read_addr` and `write_addr` hold their last value between transactions. `byte_en` and `mem_write` are 0 outside W_MEM.

## Timing
- All outputs are registered.
- Reset values:
  - All ready and valid outputs are 0.
  - `mem_write = 0`, `byte_en = 0`.
  - Addresses, `write_data` and `s_rdata` are 0.
  - `s_bresp = s_rresp = 2'b00`.
  - State = IDLE, `last_was_write = 0`.
- Write, request seen in IDLE at cycle 0:
  - cycle 1: `awready`/`wready` handshake.
  - cycle 2: `mem_write`.
  - cycle 3: `bvalid` earliest.
- Read, request seen in IDLE at cycle 0:
  - cycle 1: `arready`.
  - cycle 2: `read_addr` valid.
  - cycle 3: `read_data` sampled.
  - cycle 4: `rvalid` earliest.
- Back-to-back: IDLE is always visited between transactions. Minimum throughput is one write per 4 cycles and one read per 5 cycles.
- No outstanding transactions; at most one in flight.
- Response valid is held indefinitely while the matching ready is low, with no timeout.
- Reset asserted in any state:
  - Next cycle: state IDLE, all outputs at reset values, the in-flight transaction dropped.
  - A reset during W_MEM still allows that cycle's memory write to complete, because the memory samples in the same edge.

## Structure
- Package `dmem_ctrl_pkg`:
  - state enum.
  - `RESP_OKAY = 2'b00`, `RESP_SLVERR = 2'b10`.
  - word-index helper constant `IDX_W = $clog2(MEM_WORDS)`.
- Single flat module, no sub-modules. The FSM, capture registers and arbitration flag all sit in one file.

## Test plan
- Full-word write: AW `0x010`, W `0xDEADBEEF`, wstrb `1111`.
  - `mem_write` pulses with `write_addr = 4`, `byte_en = 1111`.
  - `bresp = OKAY` at cycle 3.
  - A following read of `0x010` returns `0xDEADBEEF` with `rvalid` at cycle 4.
- Byte write: wstrb `0100`, data `0x00AB0000` to `0x010` over `0xDEADBEEF`. A read of `0x010` returns `0xDEABBEEF`.
- Simultaneous AW+W and AR from reset:
  - The write is granted first; the read is granted next.
  - With both repeatedly pending, grants alternate W, R, W, R.
- Out of range: write `0x400` gives no `mem_write` and `bresp = SLVERR`. Read `0x7FC` gives `rdata = 0`, `rresp = SLVERR`.
- Backpressure: hold `rready = 0` for 10 cycles. `rvalid` and `rdata` stay stable, and no new AR is accepted during that time.
- Reset mid-read, asserted in R_DATA: next cycle all outputs are at reset values. A new read after reset completes normally.

Source files
------------

// File: rtl/dmem_axil_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite data-memory controller.
package dmem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_ACC,
      ST_W_MEM,
      ST_W_RESP,
      ST_R_ACC,
      ST_R_MEM,
      ST_R_DATA,
      ST_R_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int DEF_MEM_WORDS = 256;
   localparam int IDX_W         = $clog2(DEF_MEM_WORDS);

endpackage

// File: rtl/dmem_axil_ctrl_if.sv
// AXI4-Lite slave channel bundle between the crossbar and the data-memory controller.
interface dmem_axil_ctrl_if #(
   parameter int ADDR_WIDTH = 12
);

   logic [ADDR_WIDTH-1:0] s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [ADDR_WIDTH-1:0] s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [31:0]           s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
             s_arready, s_rdata, s_rresp, s_rvalid
   );

endinterface

// File: rtl/dmem_axil_ctrl.sv
// AXI4-Lite slave that sequences one read or write at a time into a synchronous-read
// data memory; every output is registered and IDLE separates consecutive transactions.
module dmem_axil_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   dmem_axil_ctrl_if.slave   s_axi,
   output logic              mem_write,
   output logic [3:0]        byte_en,
   output logic [11:0]       write_addr,
   output logic [11:0]       read_addr,
   output logic [31:0]       write_data,
   input  logic [31:0]       read_data
);

   localparam int                    LW       = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(MEM_WORDS - 1);

   function automatic logic [11:0] f_word_idx(input logic [ADDR_WIDTH-1:0] a);
      return 12'((a >> 2) & IDX_MASK);
   endfunction

   function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >> (LW + 2)) == '0;
   endfunction

   state_t      r_state, w_next;
   logic        r_last_was_write;
   logic        r_w_oor, r_r_oor;
   logic        r_awready, r_wready, r_arready;
   logic        r_bvalid, r_rvalid;
   logic [1:0]  r_bresp, r_rresp;
   logic [31:0] r_rdata;
   logic        r_mem_write;
   logic [3:0]  r_byte_en;
   logic [11:0] r_write_addr, r_read_addr;
   logic [31:0] r_write_data;
   logic        w_wr_req, w_rd_req;

   // A write needs both AW and W present; AW alone is never accepted.
   assign w_wr_req = s_axi.s_awvalid && s_axi.s_wvalid;
   assign w_rd_req = s_axi.s_arvalid;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_wr_req && (!w_rd_req || !r_last_was_write)) w_next = ST_W_ACC;
            else if (w_rd_req)                                w_next = ST_R_ACC;
         end
         ST_W_ACC:  w_next = ST_W_MEM;
         ST_W_MEM:  w_next = ST_W_RESP;
         ST_W_RESP: if (s_axi.s_bready) w_next = ST_IDLE;
         ST_R_ACC:  w_next = ST_R_MEM;
         ST_R_MEM:  w_next = ST_R_DATA;
         ST_R_DATA: w_next = ST_R_RESP;
         ST_R_RESP: if (s_axi.s_rready) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_last_was_write <= 1'b0;
         r_w_oor          <= 1'b0;
         r_r_oor          <= 1'b0;
         r_awready        <= 1'b0;
         r_wready         <= 1'b0;
         r_arready        <= 1'b0;
         r_bvalid         <= 1'b0;
         r_rvalid         <= 1'b0;
         r_bresp          <= RESP_OKAY;
         r_rresp          <= RESP_OKAY;
         r_rdata          <= '0;
         r_mem_write      <= 1'b0;
         r_byte_en        <= '0;
         r_write_addr     <= '0;
         r_read_addr      <= '0;
         r_write_data     <= '0;
      end else begin
         r_state     <= w_next;
         r_awready   <= (w_next == ST_W_ACC);
         r_wready    <= (w_next == ST_W_ACC);
         r_arready   <= (w_next == ST_R_ACC);
         r_bvalid    <= (w_next == ST_W_RESP);
         r_rvalid    <= (w_next == ST_R_RESP);
         r_mem_write <= 1'b0;
         r_byte_en   <= '0;

         if (r_state == ST_IDLE && w_next != ST_IDLE)
            r_last_was_write <= (w_next == ST_W_ACC);

         if (r_state == ST_W_ACC) begin
            r_write_addr <= f_word_idx(s_axi.s_awaddr);
            r_write_data <= s_axi.s_wdata;
            r_w_oor      <= !f_in_range(s_axi.s_awaddr);
            r_byte_en    <= s_axi.s_wstrb;
            r_mem_write  <= f_in_range(s_axi.s_awaddr) && (|s_axi.s_wstrb);
         end

         if (r_state == ST_W_MEM)
            r_bresp <= r_w_oor ? RESP_SLVERR : RESP_OKAY;

         if (r_state == ST_R_ACC) begin
            r_read_addr <= f_word_idx(s_axi.s_araddr);
            r_r_oor     <= !f_in_range(s_axi.s_araddr);
         end

         // Memory data for read_addr is present now, one cycle after R_MEM presented it.
         if (r_state == ST_R_DATA) begin
            r_rdata <= r_r_oor ? 32'h0 : read_data;
            r_rresp <= r_r_oor ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign s_axi.s_awready = r_awready;
   assign s_axi.s_wready  = r_wready;
   assign s_axi.s_arready = r_arready;
   assign s_axi.s_bvalid  = r_bvalid;
   assign s_axi.s_bresp   = r_bresp;
   assign s_axi.s_rvalid  = r_rvalid;
   assign s_axi.s_rdata   = r_rdata;
   assign s_axi.s_rresp   = r_rresp;
   assign mem_write       = r_mem_write;
   assign byte_en         = r_byte_en;
   assign write_addr      = r_write_addr;
   assign read_addr       = r_read_addr;
   assign write_data      = r_write_data;

endmodule
